// File: rtl/ber_window_calc.sv
// Windowed bit-error counter with a restoring divider producing a
// fixed-point BER (errors/bits scaled by 2^FRAC_W) on a valid/ready port.
module ber_window_calc #(
    parameter int CNT_W  = 32,
    parameter int ERR_W  = 16,
    parameter int FRAC_W = 16
) (
    input  logic              clock,
    input  logic              channel_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  window_len,
    input  logic              bit_valid,
    input  logic              bit_error,
    input  logic              ber_ready,
    output logic              ber_valid,
    output logic [FRAC_W-1:0] ber_value,
    output logic [ERR_W-1:0]  err_total,
    output logic [CNT_W-1:0]  bits_total,
    output logic              err_sat,
    output logic              busy
);

    localparam int DCW = $clog2(FRAC_W + 2);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DIVIDE,
        HOLD
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  win_len;
    logic [CNT_W:0]    rem;
    logic [FRAC_W-1:0] quo;
    logic [DCW-1:0]    div_cnt;

    logic [CNT_W-1:0]  bits_inc;
    logic              start_ok;
    logic              div_last;
    logic              rem_ge;
    logic [CNT_W:0]    rem_sub;

    assign bits_inc = bits_total + 1'b1;
    assign start_ok = start && (window_len != '0);
    assign div_last = (div_cnt == DCW'(FRAC_W + 1));
    assign rem_ge   = (rem >= {1'b0, bits_total});
    assign rem_sub  = rem_ge ? (rem - {1'b0, bits_total}) : rem;

    assign busy      = (state_q != IDLE);
    assign ber_valid = (state_q == HOLD);

    always_ff @(posedge clock or posedge channel_reset) begin
        if (channel_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) state_d = COUNT;
            end
            COUNT: begin
                if (abort) state_d = IDLE;
                else if (bit_valid && (bits_inc == win_len)) state_d = DIVIDE;
            end
            DIVIDE: begin
                if (abort) state_d = IDLE;
                else if (div_last) state_d = HOLD;
            end
            HOLD: begin
                if (abort || ber_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge channel_reset) begin
        if (channel_reset) begin
            win_len    <= '0;
            err_total  <= '0;
            bits_total <= '0;
            err_sat    <= 1'b0;
            ber_value  <= '0;
            rem        <= '0;
            quo        <= '0;
            div_cnt    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        win_len    <= window_len;
                        err_total  <= '0;
                        bits_total <= '0;
                        err_sat    <= 1'b0;
                    end
                end
                COUNT: begin
                    div_cnt <= '0;
                    if (!abort && bit_valid) begin
                        bits_total <= bits_inc;
                        if (bit_error) begin
                            if (err_total == '1) err_sat <= 1'b1;
                            else err_total <= err_total + 1'b1;
                        end
                    end
                end
                DIVIDE: begin
                    if (!abort) begin
                        div_cnt <= div_cnt + 1'b1;
                        // First cycle loads the remainder; the rest each resolve one quotient bit
                        if (div_cnt == '0) begin
                            rem <= (CNT_W + 1)'(err_total);
                            quo <= '0;
                        end else begin
                            rem <= rem_sub << 1;
                            quo <= {quo[FRAC_W-2:0], rem_ge};
                            if (div_last) begin
                                ber_value <= quo[FRAC_W-1] ? '1
                                           : {quo[FRAC_W-2:0], rem_ge};
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ber_window_calc.sv
// Directed bench for ber_window_calc: table of windows plus hand sequences
// for gappy input, back-pressure, saturation, abort and async reset.
module tb_ber_window_calc;

    logic        clock = 1'b0;
    logic        channel_reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] window_len = '0;
    logic        bit_valid = 1'b0;
    logic        bit_error = 1'b0;
    logic        ber_ready = 1'b0;

    logic        ber_valid, err_sat, busy;
    logic [15:0] ber_value, err_total;
    logic [31:0] bits_total;

    logic        v4, sat4, busy4;
    logic [15:0] val4;
    logic [3:0]  err4;
    logic [31:0] bits4;

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] last_ber;

    always #5 clock = ~clock;

    ber_window_calc dut (
        .clock(clock), .channel_reset(channel_reset), .start(start),
        .abort(abort), .window_len(window_len), .bit_valid(bit_valid),
        .bit_error(bit_error), .ber_ready(ber_ready), .ber_valid(ber_valid),
        .ber_value(ber_value), .err_total(err_total),
        .bits_total(bits_total), .err_sat(err_sat), .busy(busy)
    );

    ber_window_calc #(.ERR_W(4)) dut4 (
        .clock(clock), .channel_reset(channel_reset), .start(start),
        .abort(abort), .window_len(window_len), .bit_valid(bit_valid),
        .bit_error(bit_error), .ber_ready(ber_ready), .ber_valid(v4),
        .ber_value(val4), .err_total(err4),
        .bits_total(bits4), .err_sat(sat4), .busy(busy4)
    );

    typedef struct {
        logic [31:0] win;
        int          nerr;
        logic [15:0] ber;
    } vec_t;

    vec_t tbl[9];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start_win(input logic [31:0] w);
        window_len = w;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input int w, input int n);
        for (int i = 0; i < w; i++) begin
            bit_valid = 1'b1;
            bit_error = (i < n);
            step();
        end
        bit_valid = 1'b0;
        bit_error = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!ber_valid && k < 100) begin
            step();
            k++;
        end
    endtask

    task automatic release_ber();
        ber_ready = 1'b1;
        step();
        ber_ready = 1'b0;
        chk("idle after transfer busy", busy, 0);
        chk("idle after transfer valid", ber_valid, 0);
    endtask

    initial begin
        int k;
        int seen;
        int pat[7];

        tbl[0] = '{win: 1000, nerr: 1,  ber: 16'h0041};
        tbl[1] = '{win: 8,    nerr: 8,  ber: 16'hFFFF};
        tbl[2] = '{win: 3,    nerr: 1,  ber: 16'h5555};
        tbl[3] = '{win: 16,   nerr: 4,  ber: 16'h4000};
        tbl[4] = '{win: 7,    nerr: 0,  ber: 16'h0000};
        tbl[5] = '{win: 100,  nerr: 99, ber: 16'd64880};
        tbl[6] = '{win: 2,    nerr: 1,  ber: 16'h8000};
        tbl[7] = '{win: 1,    nerr: 1,  ber: 16'hFFFF};
        tbl[8] = '{win: 1,    nerr: 0,  ber: 16'h0000};

        repeat (2) @(posedge clock);
        #1;
        chk("reset ber_valid", ber_valid, 0);
        chk("reset ber_value", ber_value, 0);
        chk("reset err_total", err_total, 0);
        chk("reset bits_total", bits_total, 0);
        chk("reset err_sat", err_sat, 0);
        chk("reset busy", busy, 0);
        channel_reset = 1'b0;
        step();

        window_len = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("zero window ignored", busy, 0);

        for (int i = 0; i < 9; i++) begin
            start_win(tbl[i].win);
            feed(int'(tbl[i].win), tbl[i].nerr);
            wait_valid(k);
            chk($sformatf("tbl%0d latency", i), k, 18);
            chk($sformatf("tbl%0d ber_value", i), ber_value, tbl[i].ber);
            chk($sformatf("tbl%0d err_total", i), err_total, tbl[i].nerr);
            chk($sformatf("tbl%0d bits_total", i), bits_total, tbl[i].win);
            chk($sformatf("tbl%0d err_sat", i), err_sat, 0);
            release_ber();
        end

        pat = '{1, 0, 0, 1, 1, 0, 1};
        start_win(4);
        for (int i = 0; i < 7; i++) begin
            bit_valid = (pat[i] != 0);
            step();
        end
        chk("gappy bits after 4th", bits_total, 4);
        bit_valid = 1'b1;
        step();
        step();
        bit_valid = 1'b0;
        chk("gappy extra not counted", bits_total, 4);
        wait_valid(k);
        chk("gappy latency", k, 16);
        chk("gappy ber_value", ber_value, 0);
        chk("gappy bits_total", bits_total, 4);
        release_ber();

        start_win(2);
        feed(2, 1);
        wait_valid(k);
        chk("hold latency", k, 18);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold%0d valid", i), ber_valid, 1);
            chk($sformatf("hold%0d value", i), ber_value, 16'h8000);
            chk($sformatf("hold%0d bits", i), bits_total, 2);
            step();
        end
        release_ber();

        ber_ready = 1'b1;
        start_win(3);
        feed(3, 2);
        wait_valid(k);
        chk("early ready latency", k, 18);
        chk("early ready value", ber_value, 16'hAAAA);
        step();
        chk("early ready valid drop", ber_valid, 0);
        chk("early ready busy", busy, 0);
        ber_ready = 1'b0;

        start_win(20);
        feed(20, 20);
        wait_valid(k);
        chk("sat latency", k, 18);
        chk("sat4 valid", v4, 1);
        chk("sat4 err_total", err4, 15);
        chk("sat4 err_sat", sat4, 1);
        chk("sat4 ber_value", val4, 16'hC000);
        chk("sat4 bits_total", bits4, 20);
        chk("sat16 err_total", err_total, 20);
        chk("sat16 err_sat", err_sat, 0);
        chk("sat16 ber_value", ber_value, 16'hFFFF);
        release_ber();
        last_ber = 16'hFFFF;

        start_win(10);
        feed(5, 1);
        bit_valid = 1'b1;
        abort = 1'b1;
        step();
        abort = 1'b0;
        bit_valid = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort bits_total", bits_total, 5);
        chk("abort err_total", err_total, 1);
        chk("abort ber_value held", ber_value, last_ber);
        seen = 0;
        repeat (20) begin
            if (ber_valid) seen++;
            step();
        end
        chk("abort no ber_valid", seen, 0);

        start_win(4);
        feed(4, 4);
        repeat (5) step();
        chk("mid divide busy", busy, 1);
        #1 channel_reset = 1'b1;
        #1;
        chk("async rst ber_value", ber_value, 0);
        chk("async rst err_total", err_total, 0);
        chk("async rst bits_total", bits_total, 0);
        chk("async rst busy", busy, 0);
        chk("async rst ber_valid", ber_valid, 0);
        chk("async rst err4", err4, 0);
        #1 channel_reset = 1'b0;
        step();
        chk("post rst busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
